// File: rtl/multicycle_control_fsm_if.sv
// Memory handshake between the multi-cycle control FSM (master) and the memory port (slave).
interface multicycle_control_fsm_if;
  logic mem_read;
  logic mem_write;
  logic i_or_d;
  logic mem_ready;

  modport master (
    output mem_read,
    output mem_write,
    output i_or_d,
    input  mem_ready
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  i_or_d,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multi-cycle RV32I core: IF -> ID -> EX -> MEM/WB, halts on ECALL.
// Optional memory wait timeout with sticky mem_error is enabled by defining MEM_TIMEOUT_EN.
module multicycle_control_fsm
`ifdef MEM_TIMEOUT_EN
  #(parameter int MEM_WAIT_MAX = 15)
`endif
(
  input  logic                            clk,
  input  logic                            reset,
  multicycle_control_fsm_if.master        mem,
  input  logic [6:0]                      opcode,
  input  logic [2:0]                      funct3,
  input  logic [2:0]                      alu_bcond,
  input  logic                            ecall_halt,
  output logic                            pc_write,
  output logic                            pc_source,
  output logic                            ir_write,
  output logic                            reg_write,
  output logic [1:0]                      wb_sel,
  output logic                            alu_src_a,
  output logic [1:0]                      alu_src_b,
  output logic [1:0]                      alu_op,
  output logic                            is_halted
`ifdef MEM_TIMEOUT_EN
  ,
  output logic                            mem_error
`endif
);

  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_EX_R    = 4'd2,
    S_EX_I    = 4'd3,
    S_WB_ALU  = 4'd4,
    S_EX_ADDR = 4'd5,
    S_MEM_RD  = 4'd6,
    S_WB_MEM  = 4'd7,
    S_MEM_WR  = 4'd8,
    S_EX_BR   = 4'd9,
    S_PC_INC  = 4'd10,
    S_EX_JAL  = 4'd11,
    S_EX_JALR = 4'd12,
    S_ECALL   = 4'd13,
    S_HALT    = 4'd14
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_t state_q, state_d;
  logic   br_taken;

  // The "greater than" flag is not needed by the supported branch set.
  logic   unused_bcond_gt;
  assign unused_bcond_gt = alu_bcond[2];

`ifdef MEM_TIMEOUT_EN
  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT_MAX - 1);
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       mem_error_q, mem_error_d;
  logic       in_mem_state;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IF;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q  <= 4'd0;
      mem_error_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
      mem_error_q <= mem_error_d;
`endif
    end
  end

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken =  alu_bcond[0];
      3'b001:  br_taken = !alu_bcond[0];
      3'b100:  br_taken =  alu_bcond[1];
      3'b101:  br_taken = !alu_bcond[1];
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_write     = 1'b0;
    pc_source    = 1'b0;
    mem.i_or_d   = 1'b0;
    mem.mem_read = 1'b0;
    mem.mem_write = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = 2'b00;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu_op       = 2'b00;
    is_halted    = 1'b0;

    case (state_q)
      S_IF: begin
        mem.mem_read = 1'b1;
        ir_write     = mem.mem_ready;
        if (mem.mem_ready) state_d = S_ID;
      end
      S_ID: begin
        // Speculatively form PC+imm in ALUOut for branches and JAL.
        alu_src_b = 2'b10;
        case (opcode)
          OP_R:               state_d = S_EX_R;
          OP_I:               state_d = S_EX_I;
          OP_LOAD, OP_STORE:  state_d = S_EX_ADDR;
          OP_BRANCH:          state_d = S_EX_BR;
          OP_JAL:             state_d = S_EX_JAL;
          OP_JALR:            state_d = S_EX_JALR;
          OP_SYSTEM:          state_d = S_ECALL;
          default:            state_d = S_PC_INC;
        endcase
      end
      S_EX_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_WB_ALU;
      end
      S_EX_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
        state_d   = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = 1'b1;
        state_d   = S_IF;
      end
      S_EX_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem.i_or_d   = 1'b1;
        mem.mem_read = 1'b1;
        if (mem.mem_ready) state_d = S_WB_MEM;
      end
      S_WB_MEM: begin
        reg_write = 1'b1;
        wb_sel    = 2'b01;
        alu_src_b = 2'b01;
        pc_write  = 1'b1;
        state_d   = S_IF;
      end
      S_MEM_WR: begin
        mem.i_or_d    = 1'b1;
        mem.mem_write = 1'b1;
        if (mem.mem_ready) begin
          alu_src_b = 2'b01;
          pc_write  = 1'b1;
          state_d   = S_IF;
        end
      end
      S_EX_BR: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        if (br_taken) begin
          pc_source = 1'b1;
          pc_write  = 1'b1;
          state_d   = S_IF;
        end else begin
          state_d   = S_PC_INC;
        end
      end
      S_PC_INC: begin
        alu_src_b = 2'b01;
        pc_write  = 1'b1;
        state_d   = S_IF;
      end
      S_EX_JAL: begin
        reg_write = 1'b1;
        wb_sel    = 2'b10;
        pc_source = 1'b1;
        pc_write  = 1'b1;
        state_d   = S_IF;
      end
      S_EX_JALR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        reg_write = 1'b1;
        wb_sel    = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_IF;
      end
      S_ECALL: begin
        state_d = ecall_halt ? S_HALT : S_PC_INC;
      end
      S_HALT: begin
        is_halted = 1'b1;
      end
      default: begin
        state_d = S_IF;
      end
    endcase

`ifdef MEM_TIMEOUT_EN
    // Counter restarts on every entry to a memory state because it is cleared whenever not waiting.
    in_mem_state = (state_q == S_IF) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    wait_cnt_d   = 4'd0;
    mem_error_d  = mem_error_q;
    if (in_mem_state && !mem.mem_ready) begin
      if (wait_cnt_q == WAIT_LAST) begin
        mem_error_d = 1'b1;
        state_d     = S_HALT;
      end else begin
        wait_cnt_d  = wait_cnt_q + 4'd1;
      end
    end
`endif

    // IF would otherwise drive mem_read during reset.
    if (!reset) begin
      pc_write      = 1'b0;
      pc_source     = 1'b0;
      mem.i_or_d    = 1'b0;
      mem.mem_read  = 1'b0;
      mem.mem_write = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      wb_sel        = 2'b00;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      is_halted     = 1'b0;
    end
  end

`ifdef MEM_TIMEOUT_EN
  assign mem_error = mem_error_q;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed self-checking bench for multicycle_control_fsm; walks each instruction class state by state.
module tb_multicycle_control_fsm;
  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [2:0] alu_bcond;
  logic       ecall_halt;
  logic       pc_write, pc_source, ir_write, reg_write, alu_src_a, is_halted;
  logic [1:0] wb_sel, alu_src_b, alu_op;
`ifdef MEM_TIMEOUT_EN
  logic       mem_error;
`endif

  int checks = 0;
  int errors = 0;

  multicycle_control_fsm_if mem_if ();

  multicycle_control_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .mem        (mem_if),
    .opcode     (opcode),
    .funct3     (funct3),
    .alu_bcond  (alu_bcond),
    .ecall_halt (ecall_halt),
    .pc_write   (pc_write),
    .pc_source  (pc_source),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .wb_sel     (wb_sel),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .is_halted  (is_halted)
`ifdef MEM_TIMEOUT_EN
    ,
    .mem_error  (mem_error)
`endif
  );

  always #5 clk = ~clk;

  // {pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write, wb_sel, alu_src_a, alu_src_b, alu_op, is_halted}
  logic [14:0] ctrl;
  assign ctrl = {pc_write, pc_source, mem_if.i_or_d, mem_if.mem_read, mem_if.mem_write, ir_write,
                 reg_write, wb_sel, alu_src_a, alu_src_b, alu_op, is_halted};

  function automatic logic [14:0] v(input logic pcw, input logic pcs, input logic iord,
                                    input logic mr, input logic mw, input logic irw, input logic rw,
                                    input logic [1:0] wb, input logic asa, input logic [1:0] asb,
                                    input logic [1:0] aop, input logic h);
    return {pcw, pcs, iord, mr, mw, irw, rw, wb, asa, asb, aop, h};
  endfunction

  localparam logic [14:0] E_ZERO       = 15'd0;
  localparam logic [14:0] E_IF_RDY     = v(0,0,0,1,0,1,0,2'b00,0,2'b00,2'b00,0);
  localparam logic [14:0] E_IF_WAIT    = v(0,0,0,1,0,0,0,2'b00,0,2'b00,2'b00,0);
  localparam logic [14:0] E_ID         = v(0,0,0,0,0,0,0,2'b00,0,2'b10,2'b00,0);
  localparam logic [14:0] E_EXR        = v(0,0,0,0,0,0,0,2'b00,1,2'b00,2'b10,0);
  localparam logic [14:0] E_EXI        = v(0,0,0,0,0,0,0,2'b00,1,2'b10,2'b11,0);
  localparam logic [14:0] E_WBALU      = v(1,0,0,0,0,0,1,2'b00,0,2'b01,2'b00,0);
  localparam logic [14:0] E_EXADDR     = v(0,0,0,0,0,0,0,2'b00,1,2'b10,2'b00,0);
  localparam logic [14:0] E_MEMRD      = v(0,0,1,1,0,0,0,2'b00,0,2'b00,2'b00,0);
  localparam logic [14:0] E_WBMEM      = v(1,0,0,0,0,0,1,2'b01,0,2'b01,2'b00,0);
  localparam logic [14:0] E_MEMWR_WAIT = v(0,0,1,0,1,0,0,2'b00,0,2'b00,2'b00,0);
  localparam logic [14:0] E_MEMWR_DONE = v(1,0,1,0,1,0,0,2'b00,0,2'b01,2'b00,0);
  localparam logic [14:0] E_EXBR_N     = v(0,0,0,0,0,0,0,2'b00,1,2'b00,2'b01,0);
  localparam logic [14:0] E_EXBR_T     = v(1,1,0,0,0,0,0,2'b00,1,2'b00,2'b01,0);
  localparam logic [14:0] E_PCINC      = v(1,0,0,0,0,0,0,2'b00,0,2'b01,2'b00,0);
  localparam logic [14:0] E_JAL        = v(1,1,0,0,0,0,1,2'b10,0,2'b00,2'b00,0);
  localparam logic [14:0] E_JALR       = v(1,0,0,0,0,0,1,2'b10,1,2'b10,2'b00,0);
  localparam logic [14:0] E_HALT       = v(0,0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1);

  task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge: check this cycle's outputs, then move to the next falling edge.
  task automatic step(input string tag, input logic [14:0] exp);
    #1;
    chk(tag, ctrl, exp);
    @(negedge clk);
  endtask

  task automatic fetch_decode(input string tag, input logic [6:0] opc);
    opcode = opc;
    mem_if.mem_ready = 1'b1;
    step({tag, "_if"}, E_IF_RDY);
    step({tag, "_id"}, E_ID);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    opcode = 7'b0110011;
    funct3 = 3'b000;
    alu_bcond = 3'b000;
    ecall_halt = 1'b0;
    mem_if.mem_ready = 1'b1;

    @(negedge clk);
    #1 chk("reset_low", ctrl, E_ZERO);
    @(negedge clk);
    reset = 1'b1;

    // ADD: IF, ID, EX_R, WB_ALU, back to IF
    fetch_decode("add", 7'b0110011);
    step("add_ex", E_EXR);
    step("add_wb", E_WBALU);

    // ADDI
    fetch_decode("addi", 7'b0010011);
    step("addi_ex", E_EXI);
    step("addi_wb", E_WBALU);

    // LW with two wait cycles in MEM_RD: 7 cycles total
    fetch_decode("lw", 7'b0000011);
    step("lw_addr", E_EXADDR);
    mem_if.mem_ready = 1'b0;
    step("lw_wait1", E_MEMRD);
    step("lw_wait2", E_MEMRD);
    mem_if.mem_ready = 1'b1;
    step("lw_rd", E_MEMRD);
    step("lw_wb", E_WBMEM);

    // SW, no wait
    fetch_decode("sw", 7'b0100011);
    step("sw_addr", E_EXADDR);
    step("sw_wr", E_MEMWR_DONE);

    // BNE not taken (equal) then taken
    funct3 = 3'b001; alu_bcond = 3'b001;
    fetch_decode("bne_n", 7'b1100011);
    step("bne_n_ex", E_EXBR_N);
    step("bne_n_inc", E_PCINC);
    alu_bcond = 3'b010;
    fetch_decode("bne_t", 7'b1100011);
    step("bne_t_ex", E_EXBR_T);

    // BLT taken, BGE not taken, unsupported funct3 not taken
    funct3 = 3'b100; alu_bcond = 3'b010;
    fetch_decode("blt", 7'b1100011);
    step("blt_ex", E_EXBR_T);
    funct3 = 3'b101;
    fetch_decode("bge", 7'b1100011);
    step("bge_ex", E_EXBR_N);
    step("bge_inc", E_PCINC);
    funct3 = 3'b110; alu_bcond = 3'b001;
    fetch_decode("bx", 7'b1100011);
    step("bx_ex", E_EXBR_N);
    step("bx_inc", E_PCINC);

    // JAL and JALR
    fetch_decode("jal", 7'b1101111);
    step("jal_ex", E_JAL);
    fetch_decode("jalr", 7'b1100111);
    step("jalr_ex", E_JALR);

    // Unknown opcode executes as NOP
    fetch_decode("nop", 7'b0000000);
    step("nop_inc", E_PCINC);

    // Fetch stall: IF holds with request stable, no IR load
    mem_if.mem_ready = 1'b0;
    step("if_wait1", E_IF_WAIT);
    step("if_wait2", E_IF_WAIT);

    // Non-halting ECALL
    ecall_halt = 1'b0;
    fetch_decode("ecall0", 7'b1110011);
    step("ecall0_ex", E_ZERO);
    step("ecall0_inc", E_PCINC);

    // Store waiting, then reset pulsed mid-wait
    fetch_decode("swr", 7'b0100011);
    step("swr_addr", E_EXADDR);
    mem_if.mem_ready = 1'b0;
    step("swr_wait1", E_MEMWR_WAIT);
    #1 chk("swr_wait2", ctrl, E_MEMWR_WAIT);
    #1 reset = 1'b0;
    #1 chk("swr_rst_async", ctrl, E_ZERO);
    mem_if.mem_ready = 1'b1;
    @(negedge clk);
    #1 chk("swr_rst_held", ctrl, E_ZERO);
    @(negedge clk);
    reset = 1'b1;
    opcode = 7'b0110011;
    step("swr_refetch", E_IF_RDY);
    step("swr_refetch_id", E_ID);
    step("swr_refetch_ex", E_EXR);
    step("swr_refetch_wb", E_WBALU);

    // Halting ECALL: HALT is sticky, no further fetch
    ecall_halt = 1'b1;
    fetch_decode("ecall1", 7'b1110011);
    step("ecall1_ex", E_ZERO);
    step("halt1", E_HALT);
    step("halt2", E_HALT);
    ecall_halt = 1'b0;
    step("halt3", E_HALT);

    // Reset recovers from HALT
    reset = 1'b0;
    #1 chk("halt_rst", ctrl, E_ZERO);
    @(negedge clk);
    reset = 1'b1;
    opcode = 7'b0010011;
    step("post_halt_if", E_IF_RDY);
    step("post_halt_id", E_ID);

`ifdef MEM_TIMEOUT_EN
    // Timeout: 15 wait cycles in IF then HALT with mem_error
    step("to_ex", E_EXI);
    step("to_wb", E_WBALU);
    mem_if.mem_ready = 1'b0;
    #1 chk("to_err_clear", {14'd0, mem_error}, 15'd0);
    for (int i = 0; i < 15; i++) step("to_wait", E_IF_WAIT);
    #1 chk("to_halt", ctrl, E_HALT);
    chk("to_err", {14'd0, mem_error}, 15'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
